quadrant_sequencer: RTL

QUADRANT_SEQUENCER -- requirements
Module: quadrant_sequencer

---
 rtl/quadrant_sequencer_if.sv | 48 ++++
 rtl/quadrant_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/quadrant_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : quadrant_sequencer_if
// Description : Bundles the job request, status, input/weight SRAM read,
//               MAC control and output SRAM write signals of the quadrant
//               sequencer.
//               master : sequencer view (drives status, SRAM and MAC controls)
//               slave  : host/memory view (drives the job request and mac_out)
// Ports       : start, in_base, kernel_len, num_outputs  (job request)
//               busy, done                               (status)
//               in_rd, in_addr, w_addr                   (input/weight reads)
//               mac_clear, mac_out                       (MAC control/result)
//               out_wr, out_addr, out_data               (output SRAM write)
// Revision    : 1.0 - initial release
// ============================================================================
interface quadrant_sequencer_if #(
   parameter int IN_AW  = 12,
   parameter int OUT_AW = 8,
   parameter int KLEN_W = 4
);
   logic              start;
   logic [IN_AW-1:0]  in_base;
   logic [KLEN_W-1:0] kernel_len;
   logic [OUT_AW-1:0] num_outputs;
   logic              busy;
   logic              done;
   logic              in_rd;
   logic [IN_AW-1:0]  in_addr;
   logic [KLEN_W-1:0] w_addr;
   logic              mac_clear;
   logic [15:0]       mac_out;
   logic              out_wr;
   logic [OUT_AW-1:0] out_addr;
   logic [15:0]       out_data;

   modport master (
      input  start, in_base, kernel_len, num_outputs, mac_out,
      output busy, done, in_rd, in_addr, w_addr, mac_clear,
             out_wr, out_addr, out_data
   );

   modport slave (
      output start, in_base, kernel_len, num_outputs, mac_out,
      input  busy, done, in_rd, in_addr, w_addr, mac_clear,
             out_wr, out_addr, out_data
   );
endinterface
`default_nettype wire

// File: rtl/quadrant_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : quadrant_sequencer
// Description : Sequences a 1-D convolution job. For each output o it streams
//               kernel_len terms (input address in_base+o+k, weight address k)
//               into an external MAC, waits for the SRAM and MAC pipeline to
//               drain, then writes the MAC result to output address o.
// Ports       : clock, reset_b (async, active-low)
//               bus : quadrant_sequencer_if.master
//               cycle_count[31:0] : busy-cycle counter, present only when
//                                   QSEQ_PERF_CNT_EN is defined
// Options     : `define QSEQ_PERF_CNT_EN to add the busy-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module quadrant_sequencer #(
   parameter int IN_AW  = 12,
   parameter int OUT_AW = 8,
   parameter int KLEN_W = 4
) (
   input  wire logic            clock,
   input  wire logic            reset_b,
   quadrant_sequencer_if.master bus
`ifdef QSEQ_PERF_CNT_EN
   ,
   output logic [31:0]          cycle_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DRAIN1 = 3'd2,
      S_DRAIN2 = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t            r_state;
   logic [OUT_AW-1:0] r_o;
   logic [KLEN_W-1:0] r_k;
   logic [IN_AW-1:0]  r_base;
   // Last term / last output indices; kernel_len=0 wraps to all-ones, which
   // is exactly 2^KLEN_W-1 and gives the full-length kernel for free.
   logic [KLEN_W-1:0] r_klen_m1;
   logic [OUT_AW-1:0] r_nout_m1;

   logic              r_busy;
   logic              r_done;
   logic              r_in_rd;
   logic [IN_AW-1:0]  r_in_addr;
   logic [KLEN_W-1:0] r_w_addr;
   logic              r_mac_clear;
   logic              r_out_wr;
   logic [OUT_AW-1:0] r_out_addr;
   logic [15:0]       r_out_data;

   // Address of the next term of the current output, and of term 0 of the
   // next output; both wrap naturally at 2^IN_AW.
   logic [IN_AW-1:0]  w_next_term_addr;
   logic [IN_AW-1:0]  w_next_out_addr;

   assign w_next_term_addr = r_base + IN_AW'(r_o) + IN_AW'(r_k) + IN_AW'(1);
   assign w_next_out_addr  = r_base + IN_AW'(r_o) + IN_AW'(1);

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         r_state     <= S_IDLE;
         r_o         <= '0;
         r_k         <= '0;
         r_base      <= '0;
         r_klen_m1   <= '0;
         r_nout_m1   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_in_rd     <= 1'b0;
         r_in_addr   <= '0;
         r_w_addr    <= '0;
         r_mac_clear <= 1'b0;
         r_out_wr    <= 1'b0;
         r_out_addr  <= '0;
         r_out_data  <= '0;
      end else begin
         // Strobes are single-cycle unless a state re-asserts them.
         r_in_rd     <= 1'b0;
         r_mac_clear <= 1'b0;
         r_out_wr    <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_base    <= bus.in_base;
                  r_klen_m1 <= bus.kernel_len - 1'b1;
                  r_nout_m1 <= bus.num_outputs - 1'b1;
                  r_o       <= '0;
                  r_k       <= '0;
                  r_busy    <= 1'b1;
                  if (bus.num_outputs != '0) begin
                     r_state   <= S_FETCH;
                     r_in_rd   <= 1'b1;
                     r_in_addr <= bus.in_base;
                     r_w_addr  <= '0;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               // Term 0 operands return one cycle after issue.
               r_mac_clear <= (r_k == '0);
               if (r_k == r_klen_m1) begin
                  r_state <= S_DRAIN1;
               end else begin
                  r_k       <= r_k + 1'b1;
                  r_in_rd   <= 1'b1;
                  r_in_addr <= w_next_term_addr;
                  r_w_addr  <= r_k + 1'b1;
               end
            end
            S_DRAIN1: begin
               r_state <= S_DRAIN2;
            end
            S_DRAIN2: begin
               // Last term has passed the SRAM and MAC register stages.
               r_state    <= S_WRITE;
               r_out_wr   <= 1'b1;
               r_out_addr <= r_o;
               r_out_data <= bus.mac_out;
            end
            S_WRITE: begin
               r_o <= r_o + 1'b1;
               if (r_o == r_nout_m1) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state   <= S_FETCH;
                  r_k       <= '0;
                  r_in_rd   <= 1'b1;
                  r_in_addr <= w_next_out_addr;
                  r_w_addr  <= '0;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.in_rd     = r_in_rd;
   assign bus.in_addr   = r_in_addr;
   assign bus.w_addr    = r_w_addr;
   assign bus.mac_clear = r_mac_clear;
   assign bus.out_wr    = r_out_wr;
   assign bus.out_addr  = r_out_addr;
   assign bus.out_data  = r_out_data;

`ifdef QSEQ_PERF_CNT_EN
   logic [31:0] r_cycle_count;

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         r_cycle_count <= '0;
      end else if ((r_state == S_IDLE) && bus.start) begin
         r_cycle_count <= '0;
      end else if (r_busy && (r_cycle_count != 32'hFFFF_FFFF)) begin
         r_cycle_count <= r_cycle_count + 32'd1;
      end
   end

   assign cycle_count = r_cycle_count;
`endif

endmodule
`default_nettype wire
